// File: rtl/subneg_pkg.sv
// Shared types and helpers for the SUBNEG execute unit.
package subneg_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic {BR_NEG = 1'b0, BR_LEQ = 1'b1} branch_mode_e;

  // Largest signed value of a given width, right-aligned in 64 bits.
  function automatic logic [63:0] smax(input int unsigned width);
    smax = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Smallest signed value; the low 'width' bits read 100..0.
  function automatic logic [63:0] smin(input int unsigned width);
    smin = ~smax(width);
  endfunction

endpackage

// File: rtl/subneg_pipe_reg.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module subneg_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load on slot free; payload only moves with a valid entry so a drain leaves it held.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // State registers, cleared by async reset so outputs read zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/subneg_exec.sv
// Two-stage SUBNEG execute: stage 1 holds the widened difference,
// stage 2 holds flags, the (wrapped or saturated) result and the next PC.
module subneg_exec
  import subneg_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter bit SAT_EN     = 1'b0,
  parameter bit BRANCH_LEQ = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in1_i,
  input  logic [WIDTH-1:0]  in2_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              neg_o,
  output logic              zero_o,
  output logic              ovf_o,
  output logic              branch_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  localparam branch_mode_e BR_MODE = BRANCH_LEQ ? BR_LEQ : BR_NEG;
  localparam logic [63:0] SMAX64 = smax(WIDTH);
  localparam logic [63:0] SMIN64 = smin(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN64[WIDTH-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [WIDTH:0]    diff;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0]  res;
    logic              neg;
    logic              zero;
    logic              ovf;
    logic              branch;
    logic [ADDR_W-1:0] next_pc;
  } s2_t;

  s1_t  s1_in, s1_out;
  s2_t  s2_in, s2_out;
  logic s1_valid, s2_ready;
  logic neg_c, zero_c, ovf_c, br_c;

  // One extra bit keeps the true sign, so neg is right even on overflow.
  always_comb begin
    s1_in        = '0;
    s1_in.diff   = {in2_i[WIDTH-1], in2_i} - {in1_i[WIDTH-1], in1_i};
    s1_in.pc     = pc_i;
    s1_in.target = target_i;
  end

  subneg_pipe_reg #(.DW($bits(s1_t))) u_s1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (in_valid_i),
    .ready_o (in_ready_o),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_out)
  );

  // Flag extraction, optional saturation and branch resolution.
  always_comb begin
    neg_c  = s1_out.diff[WIDTH];
    zero_c = (s1_out.diff == '0);
    ovf_c  = s1_out.diff[WIDTH] ^ s1_out.diff[WIDTH-1];
    br_c   = neg_c | ((BR_MODE == BR_LEQ) & zero_c);
    s2_in         = '0;
    s2_in.neg     = neg_c;
    s2_in.zero    = zero_c;
    s2_in.ovf     = ovf_c;
    s2_in.branch  = br_c;
    s2_in.res     = (SAT_EN && ovf_c) ? (neg_c ? SMIN : SMAX) : s1_out.diff[WIDTH-1:0];
    s2_in.next_pc = br_c ? s1_out.target : s1_out.pc + PC_ONE;
  end

  subneg_pipe_reg #(.DW($bits(s2_t))) u_s2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_in),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (s2_out)
  );

  assign out_o     = s2_out.res;
  assign neg_o     = s2_out.neg;
  assign zero_o    = s2_out.zero;
  assign ovf_o     = s2_out.ovf;
  assign branch_o  = s2_out.branch;
  assign next_pc_o = s2_out.next_pc;

endmodule

// File: doc/subneg_exec.md
Name: subneg_exec

Overview:
- Registered execute unit for the SUBNEG machine.
- Computes out = in2 - in1 with a full-precision sign and overflow, and resolves the branch (next_pc = target or pc+1).
- Two-stage valid/ready pipeline with backpressure, one result per cycle.
- Adds selectable wrap/saturate arithmetic and a SUBNEG/SUBLEQ branch mode; sits between the operand-fetch and writeback/PC-update logic.

Parameters:
- WIDTH, 8, data operand width in bits (>=2).
- ADDR_W, 8, program counter / branch target width.
- SAT_EN, 0, 0 = two's-complement wrap on overflow, 1 = saturate to the signed min/max.
- BRANCH_LEQ, 0, 0 = branch if result < 0 (SUBNEG), 1 = branch if result <= 0 (SUBLEQ).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit accepts the request this cycle.
- in1  input  WIDTH  signed subtrahend.
- in2  input  WIDTH  signed minuend.
- pc  input  ADDR_W  address of the current instruction.
- target  input  ADDR_W  branch target.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  signed result.
- neg  output  1  true mathematical result < 0.
- zero  output  1  true mathematical result == 0.
- ovf  output  1  signed overflow of the WIDTH-bit result.
- branch  output  1  branch taken.
- next_pc  output  ADDR_W  next fetch address.

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
- While rst_n = 0:
  - both stage valids clear.
  - All outputs read 0: out, neg, zero, ovf, branch, next_pc, out_valid.
  - in_ready = 1.
- Reset mid-operation discards all in-flight entries; nothing is emitted after reset release.
- Handshake:
  - Transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is combinational from out_ready; there is no combinational path from in_valid to out.
- Latency: an accepted request appears on the outputs 2 cycles later if not stalled. Throughput is 1 per cycle under continuous out_ready.
- Stall: while out_valid & !out_ready, every output holds stable. With both stages full, in_ready = 0 and no entry is dropped or duplicated. Order is preserved.
- Stage 1 registers:
  - diff = sext(in2) - sext(in1), computed to WIDTH+1 bits.
  - pc and target.
- Stage 2 registers:
  - ovf = diff[WIDTH] != diff[WIDTH-1].
  - neg = diff[WIDTH]; this is the true sign and is valid even on overflow.
  - zero = (diff == 0).
  - out: if !ovf or SAT_EN = 0, out = diff[WIDTH-1:0]. Otherwise out = neg ? signed min : signed max.
  - branch = neg | (BRANCH_LEQ & zero).
  - next_pc = branch ? target : pc + 1, modulo 2^ADDR_W (wraps 2^ADDR_W-1 to 0).
- in1 = in2 always gives zero = 1, ovf = 0.
- Data registers update only on their stage load with valid input. Valid bits clear when a stage drains without refill.

Decomposition:
- Package subneg_pkg:
  - default WIDTH/ADDR_W localparams.
  - functions smax(width)/smin(width).
  - enum branch_mode_e {BR_NEG, BR_LEQ}, mapped from BRANCH_LEQ.
- One sub-module: subneg_pipe_reg, a generic valid/ready register slice parameterised by payload width.
  - Instantiated twice.
  - Arithmetic sits between the two instances inside subneg_exec.

Test Plan:
- WIDTH=8: in1=3, in2=10, pc=5, target=40, out_ready=1 -> 2 cycles later out=7, neg=0, zero=0, ovf=0, branch=0, next_pc=6.
- in1=10, in2=3, pc=5, target=40 -> out=-7, neg=1, branch=1, next_pc=40.
- Overflow, in1=1, in2=-128:
  - SAT_EN=0 -> out=127, ovf=1, neg=1, branch=1.
  - SAT_EN=1 -> out=-128.
- Overflow, in1=-1, in2=127:
  - SAT_EN=0 -> out=-128, ovf=1, neg=0, branch=0.
  - SAT_EN=1 -> out=127.
- in1=in2=42 -> out=0, zero=1:
  - BRANCH_LEQ=0 -> branch=0, next_pc=pc+1.
  - BRANCH_LEQ=1 -> branch=1, next_pc=target.
- Wrap: pc=255, ADDR_W=8, no branch -> next_pc=0.
- Backpressure: 4 back-to-back requests, out_ready=0 for cycles 2-5 ->
  - in_ready falls once 2 entries are held.
  - Outputs stay stable throughout the stall.
  - After release, all 4 results arrive in order, none lost or duplicated.
- Then rst_n pulsed low with 2 entries in flight -> out_valid=0 and in_ready=1 immediately; nothing emitted after release.
